ram_pattern_buf: RTL

//  Parametrised simple-dual-port RAM on a single clock. A post-reset init sequencer fills the

---
 rtl/ram_pattern_buf_if.sv | 29 ++
 rtl/ram_pattern_buf.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_pattern_buf_if.sv
// Purpose: bundles the write, read and status signals of the pattern RAM.
// Latency: none, wiring only.
// Backpressure: none; the write and read strobes are accepted only while init_busy is low.
interface ram_pattern_buf_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
);
  logic                  wr_en;
  logic [AWIDTH-1:0]     wr_addr;
  logic [DWIDTH-1:0]     wr_data;
  logic [DWIDTH/8-1:0]   wr_be;
  logic                  rd_en;
  logic [AWIDTH-1:0]     rd_addr;
  logic [DWIDTH-1:0]     rd_data;
  logic                  rd_valid;
  logic                  init_busy;

  // The user side issues requests and receives results.
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  // The RAM side serves the requests.
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/ram_pattern_buf.sv
// Purpose: simple-dual-port RAM with byte enables and a post-reset zero or pattern fill.
// Latency: read data and rd_valid appear 1 + OUT_REG edges after the edge that samples rd_en.
// Backpressure: none; user writes and reads are dropped while init_busy is high.
module ram_pattern_buf #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 7,
  parameter     RAM_TYPE    = "block",
  parameter int INIT_MODE   = 2,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic            clk,
  input  logic            reset,
  ram_pattern_buf_if.slave bus
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_MODE != 0) ? ST_INIT : ST_RUN;

  // Test pattern word k, replicated or truncated to the data width.
  function automatic logic [DWIDTH-1:0] pattern(input logic [3:0] k);
    logic [15:0]       p;
    logic [DWIDTH-1:0] v;
    case (k)
      4'd0:    p = 16'h0001;
      4'd1:    p = 16'hAAAA;
      4'd2:    p = 16'h5555;
      4'd3:    p = 16'hFFFF;
      4'd4:    p = 16'hF0F0;
      4'd5:    p = 16'h0F0F;
      4'd6:    p = 16'hCCCC;
      4'd7:    p = 16'h3333;
      4'd8:    p = 16'h0002;
      default: p = 16'h0004;
    endcase
    for (int i = 0; i < DWIDTH; i++) v[i] = p[i % 16];
    return v;
  endfunction

  logic [0:0]        state;
  logic [AWIDTH-1:0] init_addr;
  logic [3:0]        init_k;
  logic              run;

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [NBYTES-1:0] mem_wbe;

  logic [DWIDTH-1:0] rd_word;
  logic              rd_fire;
  logic [DWIDTH-1:0] q1_data;
  logic              q1_vld;

  (* ram_style = RAM_TYPE *) logic [DWIDTH-1:0] mem [DEPTH];

  assign run           = (state == ST_RUN);
  assign bus.init_busy = (state == ST_INIT);

  // Init sequencer: one address per cycle, pattern index wraps 9 -> 0, then RUN forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RESET;
      init_addr <= '0;
      init_k    <= '0;
    end else if (state == ST_INIT) begin
      init_addr <= init_addr + AWIDTH'(1);
      init_k    <= (init_k == 4'd9) ? 4'd0 : init_k + 4'd1;
      if (init_addr == LAST_ADDR) state <= ST_RUN;
    end
  end

  // Write port mux: the sequencer owns the port during init, the user afterwards.
  always_comb begin
    mem_we    = bus.wr_en && run;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    mem_wbe   = bus.wr_be;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr;
      mem_wdata = (INIT_MODE == 1) ? '0 : pattern(init_k);
      mem_wbe   = '1;
    end
  end

  // Byte-masked write into the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Read word, with same-cycle write bytes forwarded when write-first is selected.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (WRITE_FIRST != 0 && bus.wr_en && run && bus.wr_addr == bus.rd_addr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
      end
    end
  end

  assign rd_fire = bus.rd_en && run;

  // First read stage: data holds its value until the next accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_data <= '0;
      q1_vld  <= 1'b0;
    end else begin
      q1_vld <= rd_fire;
      if (rd_fire) q1_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DWIDTH-1:0] q2_data;
      logic              q2_vld;
      // Optional output register: forwards only completed reads so data still holds.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q2_data <= '0;
          q2_vld  <= 1'b0;
        end else begin
          q2_vld <= q1_vld;
          if (q1_vld) q2_data <= q1_data;
        end
      end
      assign bus.rd_data  = q2_data;
      assign bus.rd_valid = q2_vld;
    end else begin : g_noreg
      assign bus.rd_data  = q1_data;
      assign bus.rd_valid = q1_vld;
    end
  endgenerate
endmodule
